interrupt_controller_n: RTL and testbench

Parametrised interrupt front end for the CPU control logic. It handles a reset vector request, one non-maskable interrupt and NUM_SRC maskable IRQ lines, each configurable as edge or level sensitive. It synchronises, latches and prioritises the sources, then runs a pending/acknowledge/running handshake with the instruction sequencer. It reports the winning source kind and IRQ index so the sequencer can select the vector.

---
 rtl/interrupt_controller_n.sv | 179 +++++++++++++++++
 tb/tb_interrupt_controller_n.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller_n.sv
// interrupt_controller_n: synchronises reset/NMI/IRQ requests, latches edge
// sources, prioritises them (reset > NMI > lowest IRQ) and runs the
// pending -> acknowledge -> running handshake with the instruction sequencer.
//
// state        | meaning
// ST_IDLE      | no request presented; arbitrates any candidate
// ST_PENDING   | request presented, re-arbitrated every enabled cycle
// ST_SERVICING | vector fetch begun; waiting for interruptDone
module interrupt_controller_n #(
    parameter int               NUM_SRC     = 4,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NUM_SRC-1:0] EDGE_SRC  = '1,
    parameter int               IDW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               enableFFs,
    input  logic               nonMaskableInterrupt,
    input  logic [NUM_SRC-1:0] irqIn,
    input  logic [NUM_SRC-1:0] irqMask,
    input  logic               processStatusRegIFlag,
    input  logic               interruptStarted,
    input  logic               interruptDone,
    output logic               pendingInterrupt,
    output logic               resetDetected,
    output logic               nmiGenerated,
    output logic               irqGenerated,
    output logic               resetRunning,
    output logic               nmiRunning,
    output logic               irqRunning,
    output logic [IDW-1:0]     irqId,
    output logic [NUM_SRC-1:0] irqPendingVec
);

    localparam int NIN = NUM_SRC + 1;   // NMI sits in the top bit of the sync vector

    typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_SERVICING} state_t;

    // kind vectors are one-hot: bit0 reset, bit1 NMI, bit2 IRQ
    localparam logic [2:0] K_RESET = 3'b001;
    localparam logic [2:0] K_NMI   = 3'b010;
    localparam logic [2:0] K_IRQ   = 3'b100;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q, sync_d;
    logic [NIN-1:0]                  prev_q, prev_d;
    logic [NUM_SRC-1:0]              epend_q, epend_d;
    logic                            nmi_q, nmi_d;
    logic                            rflag_q, rflag_d;
    logic                            pend_q, pend_d;
    logic [2:0]                      gen_q, gen_d;
    logic [2:0]                      run_q, run_d;
    logic [IDW-1:0]                  id_q, id_d;

    logic [NIN-1:0]                  sync_out, rise;
    logic [NUM_SRC-1:0]              pend_vec, elig, clr_irq;
    logic                            sel_irq, clr_reset, clr_nmi;
    logic [IDW-1:0]                  sel_id;
    logic [2:0]                      cand;

    // synchroniser shift, edge detection and source latches
    always_comb begin
        sync_out = sync_q[SYNC_STAGES-1];
        sync_d   = {sync_q[SYNC_STAGES-2:0], {nonMaskableInterrupt, irqIn}};
        prev_d   = sync_out;
        rise     = sync_out & ~prev_q;
        pend_vec = (EDGE_SRC & epend_q) | (~EDGE_SRC & sync_out[NUM_SRC-1:0]);
        elig     = pend_vec & irqMask & {NUM_SRC{~processStatusRegIFlag}};
        // set wins over the acknowledge clear
        epend_d  = (epend_q & ~clr_irq) | (rise[NUM_SRC-1:0] & EDGE_SRC);
        nmi_d    = (nmi_q & ~clr_nmi) | rise[NUM_SRC];
        rflag_d  = rflag_q & ~clr_reset;
    end

    // lowest-index eligible IRQ, then fixed kind priority
    always_comb begin
        sel_irq = 1'b0;
        sel_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_irq = 1'b1;
                sel_id  = IDW'(i);
            end
        end
        if (rflag_q)      cand = K_RESET;
        else if (nmi_q)   cand = K_NMI;
        else if (sel_irq) cand = K_IRQ;
        else              cand = 3'b000;
    end

    // handshake FSM: next state, registered outputs and acknowledge clears
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        gen_d     = gen_q;
        run_d     = run_q;
        id_d      = id_q;
        clr_reset = 1'b0;
        clr_nmi   = 1'b0;
        clr_irq   = '0;
        case (state_q)
            ST_IDLE: begin
                gen_d = '0;
                if (cand != 3'b000) begin
                    state_d = ST_PENDING;
                    pend_d  = 1'b1;
                    gen_d   = cand;
                    id_d    = (cand == K_IRQ) ? sel_id : '0;
                end
            end
            ST_PENDING: begin
                if (interruptStarted) begin
                    // service what the sequencer was shown, not a same-cycle arrival
                    state_d   = ST_SERVICING;
                    pend_d    = 1'b0;
                    gen_d     = '0;
                    run_d     = gen_q;
                    clr_reset = gen_q[0];
                    clr_nmi   = gen_q[1];
                    clr_irq   = gen_q[2] ? (EDGE_SRC & (NUM_SRC'(1) << id_q)) : '0;
                end else if (cand != 3'b000) begin
                    gen_d = cand;
                    id_d  = (cand == K_IRQ) ? sel_id : '0;
                end else begin
                    state_d = ST_IDLE;
                    pend_d  = 1'b0;
                    gen_d   = '0;
                    id_d    = '0;
                end
            end
            ST_SERVICING: begin
                if (interruptDone) begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                    id_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // all flops advance only when enableFFs is high
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            sync_q  <= '0;
            prev_q  <= '0;
            epend_q <= '0;
            nmi_q   <= 1'b0;
            rflag_q <= 1'b1;
            pend_q  <= 1'b0;
            gen_q   <= K_RESET;
            run_q   <= '0;
            id_q    <= '0;
        end else if (enableFFs) begin
            state_q <= state_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            epend_q <= epend_d;
            nmi_q   <= nmi_d;
            rflag_q <= rflag_d;
            pend_q  <= pend_d;
            gen_q   <= gen_d;
            run_q   <= run_d;
            id_q    <= id_d;
        end
    end

    assign pendingInterrupt = pend_q;
    assign resetDetected    = gen_q[0];
    assign nmiGenerated     = gen_q[1];
    assign irqGenerated     = gen_q[2];
    assign resetRunning     = run_q[0];
    assign nmiRunning       = run_q[1];
    assign irqRunning       = run_q[2];
    assign irqId            = id_q;
    assign irqPendingVec    = pend_vec;

endmodule

// File: tb/tb_interrupt_controller_n.sv
// Randomised and scenario bench for interrupt_controller_n against a
// behavioural model built from an input history queue and abstract modes.
module tb_interrupt_controller_n;

    localparam int               NS   = 4;
    localparam int               S    = 2;
    localparam logic [NS-1:0]    EDGE = 4'b1110;   // IRQ0 level, others edge
    localparam int               IDW  = 2;

    logic          clk = 1'b0;
    logic          nrst, enableFFs, nmi, psr_i, started, idone;
    logic [NS-1:0] irq_in, irq_mask;
    logic          pending, rst_det, nmi_gen, irq_gen, rst_run, nmi_run, irq_run;
    logic [IDW-1:0] irq_id;
    logic [NS-1:0] pend_vec;

    int n_vec  = 0;
    int n_miss = 0;

    interrupt_controller_n #(.NUM_SRC(NS), .SYNC_STAGES(S), .EDGE_SRC(EDGE)) dut (
        .clk(clk), .nrst(nrst), .enableFFs(enableFFs),
        .nonMaskableInterrupt(nmi), .irqIn(irq_in), .irqMask(irq_mask),
        .processStatusRegIFlag(psr_i), .interruptStarted(started),
        .interruptDone(idone), .pendingInterrupt(pending),
        .resetDetected(rst_det), .nmiGenerated(nmi_gen), .irqGenerated(irq_gen),
        .resetRunning(rst_run), .nmiRunning(nmi_run), .irqRunning(irq_run),
        .irqId(irq_id), .irqPendingVec(pend_vec)
    );

    always #5 clk = ~clk;

    // reference model: mode 0 idle / 1 presenting / 2 servicing;
    // kind 0 none / 1 reset / 2 NMI / 3 IRQ
    logic [NS:0]   hist[$];
    logic [NS-1:0] m_epend;
    bit            m_rflag, m_nlatch, m_fresh;
    int            m_mode, m_kind, m_id;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= S; k++) hist.push_back('0);
        m_epend = '0; m_rflag = 1; m_nlatch = 0; m_fresh = 1;
        m_mode = 0; m_kind = 0; m_id = 0;
    endtask

    task automatic model_edge();
        logic [NS:0]   cur, prv, rise;
        logic [NS-1:0] pv;
        int  ck, cid;
        bit  ack, done;
        cur  = hist[S-1];
        prv  = hist[S];
        rise = cur & ~prv;
        for (int i = 0; i < NS; i++) pv[i] = EDGE[i] ? m_epend[i] : cur[i];
        ck = 0; cid = 0;
        if (m_rflag) ck = 1;
        else if (m_nlatch) ck = 2;
        else begin
            for (int i = 0; i < NS; i++)
                if (pv[i] && irq_mask[i] && !psr_i) begin ck = 3; cid = i; break; end
        end
        ack  = (m_mode == 1) && started;
        done = (m_mode == 2) && idone;
        for (int i = 0; i < NS; i++)
            if (EDGE[i]) m_epend[i] = (m_epend[i] && !(ack && m_kind == 3 && m_id == i)) || rise[i];
        m_nlatch = (m_nlatch && !(ack && m_kind == 2)) || rise[NS];
        m_rflag  = m_rflag && !(ack && m_kind == 1);
        case (m_mode)
            0: if (ck != 0) begin m_mode = 1; m_kind = ck; m_id = cid; end
            1: if (ack) m_mode = 2;
               else if (ck != 0) begin m_kind = ck; m_id = cid; end
               else begin m_mode = 0; m_kind = 0; end
            default: if (done) begin m_mode = 0; m_kind = 0; end
        endcase
        m_fresh = 0;
        hist.push_front({nmi, irq_in});
        void'(hist.pop_back());
    endtask

    task automatic compare_all();
        logic [NS-1:0] epv;
        for (int i = 0; i < NS; i++) epv[i] = EDGE[i] ? m_epend[i] : hist[S-1][i];
        chk("pending",  32'(pending), 32'(m_mode == 1));
        chk("rst_det",  32'(rst_det), 32'(m_fresh || (m_mode == 1 && m_kind == 1)));
        chk("nmi_gen",  32'(nmi_gen), 32'(m_mode == 1 && m_kind == 2));
        chk("irq_gen",  32'(irq_gen), 32'(m_mode == 1 && m_kind == 3));
        chk("rst_run",  32'(rst_run), 32'(m_mode == 2 && m_kind == 1));
        chk("nmi_run",  32'(nmi_run), 32'(m_mode == 2 && m_kind == 2));
        chk("irq_run",  32'(irq_run), 32'(m_mode == 2 && m_kind == 3));
        chk("pend_vec", 32'(pend_vec), 32'(epv));
        if (m_mode != 0 && m_kind == 3) chk("irq_id", 32'(irq_id), 32'(m_id));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (nrst && enableFFs) model_edge();
        #1;
        compare_all();
    endtask

    // run until pendingInterrupt rises; expiry counts as a failed comparison
    task automatic wait_pending(input string tag, output int n);
        n = 0;
        while (!pending && n < 20) begin cycle(); n++; end
        if (!pending) chk(tag, 32'(pending), 32'd1);
    endtask

    task automatic ack_and_done();
        started = 1; cycle(); started = 0;
        cycle();
        idone = 1; cycle(); idone = 0;
    endtask

    int n;
    logic p_hold, g_hold;

    initial begin
        nrst = 0; enableFFs = 1; nmi = 0; psr_i = 0; started = 0; idone = 0;
        irq_in = '0; irq_mask = '1;
        model_reset();
        #23;
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_det_rst", 32'(rst_det), 32'd1);
        chk("rst_irq_id",  32'(irq_id),  32'd0);
        chk("rst_running", 32'({rst_run, nmi_run, irq_run}), 32'd0);
        nrst = 1;
        cycle();
        chk("rst_first_edge", 32'({pending, rst_det}), 32'b11);
        started = 1; cycle(); started = 0;
        chk("rst_ack", 32'({pending, rst_run}), 32'b01);
        idone = 1; cycle(); idone = 0;
        chk("rst_done_idle", 32'({pending, rst_det, nmi_gen, irq_gen, rst_run, nmi_run, irq_run}), 32'd0);

        // edge IRQ2 latency: sampled at edge 1, presented at edge 4
        irq_in[2] = 1;
        wait_pending("irq2_timeout", n);
        chk("irq2_latency", 32'(n), 32'd4);
        chk("irq2_id", 32'({irq_gen, irq_id}), 32'b110);
        started = 1; cycle(); started = 0;
        chk("irq2_ack", 32'({irq_run, pend_vec[2]}), 32'b10);
        idone = 1; cycle(); idone = 0;
        irq_in[2] = 0;
        repeat (3) cycle();

        // NMI pre-empts a presented IRQ1, then IRQ1 is re-issued
        irq_in[1] = 1;
        wait_pending("irq1_timeout", n);
        nmi = 1; cycle(); nmi = 0;
        n = 0;
        while (!nmi_gen && n < 10) begin cycle(); n++; end
        chk("nmi_preempt", 32'({nmi_gen, irq_gen}), 32'b10);
        ack_and_done();
        wait_pending("irq1_reissue_timeout", n);
        chk("irq1_reissue", 32'({irq_gen, irq_id}), 32'b101);
        ack_and_done();
        irq_in[1] = 0;
        repeat (3) cycle();

        // level IRQ0 withdrawn by the I flag and restored
        irq_in[0] = 1;
        wait_pending("irq0_timeout", n);
        chk("irq0_id", 32'({irq_gen, irq_id}), 32'b100);
        psr_i = 1; cycle();
        chk("iflag_drop", 32'(pending), 32'd0);
        psr_i = 0; cycle();
        chk("iflag_restore", 32'(pending), 32'd1);
        started = 1; cycle(); started = 0;
        irq_in[0] = 0;
        idone = 1; cycle(); idone = 0;
        repeat (3) cycle();

        // IRQ1 and IRQ3 together: index 1 first, then 3
        irq_in[1] = 1; irq_in[3] = 1; cycle(); irq_in = '0;
        wait_pending("dual_timeout", n);
        chk("dual_first", 32'(irq_id), 32'd1);
        ack_and_done();
        wait_pending("dual2_timeout", n);
        chk("dual_second", 32'(irq_id), 32'd3);

        // freeze while presenting IRQ3, with an NMI pulse inside the freeze
        p_hold = pending; g_hold = irq_gen;
        enableFFs = 0;
        for (int k = 0; k < 5; k++) begin
            nmi = (k == 1 || k == 2);
            cycle();
            chk("freeze_hold", 32'({pending, irq_gen, nmi_gen}), 32'({p_hold, g_hold, 1'b0}));
        end
        nmi = 0; enableFFs = 1;
        repeat (4) cycle();
        chk("freeze_nmi_unseen", 32'(nmi_gen), 32'd0);
        ack_and_done();

        // randomised traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NS; i++) if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
            nmi       = ($urandom_range(15) == 0);
            if ($urandom_range(31) == 0) irq_mask = NS'($urandom);
            if ($urandom_range(29) == 0) psr_i = ~psr_i;
            started   = (m_mode == 1) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
            idone     = (m_mode == 2) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
            enableFFs = ($urandom_range(9) != 0);
            if ($urandom_range(399) == 0) begin
                nrst = 0;
                model_reset();
                #1;
                compare_all();
                #2 nrst = 1;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
